// File: rtl/frame_stream_reader_if.sv
// frame_stream_reader_if: command, read-data, output-FIFO and status signals
// of the frame stream reader. master = the reader, slave = its environment.
interface frame_stream_reader_if #(
    parameter int ADDR_WIDTH = 21,
    parameter int BUF_W      = 2
);
    logic                  frame_req;
    logic [BUF_W-1:0]      buf_sel;
    logic                  cmd;
    logic                  cmd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           rd_data;
    logic                  rd_data_valid;
    logic [16:0]           out_data;
    logic                  out_wr_en;
    logic                  out_full;
    logic                  busy;
    logic                  frame_done;
    logic                  error;

    modport master (
        input  frame_req, buf_sel, rd_data, rd_data_valid, out_full,
        output cmd, cmd_en, addr, out_data, out_wr_en, busy, frame_done, error
    );

    modport slave (
        output frame_req, buf_sel, rd_data, rd_data_valid, out_full,
        input  cmd, cmd_en, addr, out_data, out_wr_en, busy, frame_done, error
    );
endinterface

// File: rtl/frame_stream_reader.sv
// frame_stream_reader: reads one frame from the SDRAM frame store in bursts
// and writes it to the output FIFO as a tagged 17-bit stream
// (start marker, pixels, end marker).
// Optional feature macro FRAME_READER_ROW_MARKER_EN: when defined, a row
// marker 17'h10001 precedes every row; when undefined, no row markers and
// no column/row counters.
module frame_stream_reader #(
    parameter int IMAGE_WIDTH  = 23,
    parameter int IMAGE_HEIGHT = 17,
    parameter int MEMORY_BURST = 32,
    parameter int NUM_BUFFERS  = 3,
    parameter int ADDR_WIDTH   = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_stream_reader_if.master bus
);
    localparam int NUM_PIX      = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int FRAME_STRIDE = NUM_PIX + MEMORY_BURST;
    localparam int NUM_BURSTS   = (NUM_PIX + MEMORY_BURST - 1) / MEMORY_BURST;
    localparam int BEATS        = MEMORY_BURST / 2;
    localparam int PIX_W        = $clog2(NUM_PIX + MEMORY_BURST);
    localparam int BST_W        = $clog2(NUM_BURSTS + 1);
    localparam int IDX_W        = $clog2(MEMORY_BURST + 1);
    localparam int IDXA_W       = $clog2(MEMORY_BURST);
    localparam int BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        IDLE, START_MARK, ISSUE, WAIT_DATA, DRAIN, END_MARK
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_cmd_en;
    logic                  r_frame_done;
    logic                  r_error;
    logic [BST_W-1:0]      r_burst;
    logic [BEAT_W-1:0]     r_beat;
    logic [IDX_W-1:0]      r_didx;
    logic [PIX_W-1:0]      r_pix;
    logic [15:0]           r_buf [MEMORY_BURST];

    logic                  w_emit;
    logic                  w_mark;
    logic                  w_drain_done;
    logic                  w_acc;
    logic [16:0]           w_word;
    logic [IDXA_W-1:0]     w_lo;
    logic [IDXA_W-1:0]     w_hi;

`ifdef FRAME_READER_ROW_MARKER_EN
    localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int ROW_W = $clog2(IMAGE_HEIGHT + 1);
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_mark_sent;   // row marker already written for current row
`endif

    // Each beat carries two pixels; the low half is the even (earlier) one.
    assign w_lo = IDXA_W'({r_beat, 1'b0});
    assign w_hi = w_lo | IDXA_W'(1);

    // Burst is fully consumed, or the frame has all its pixels (over-read tail dropped).
    assign w_drain_done = (r_didx == IDX_W'(MEMORY_BURST)) || (r_pix == PIX_W'(NUM_PIX));

    // Select the word presented to the FIFO in the current state.
    always_comb begin
        w_emit = 1'b0;
        w_mark = 1'b0;
        w_word = '0;
        case (r_state)
            START_MARK: begin
                w_emit = 1'b1;
                w_word = 17'h10000;
            end
            DRAIN: begin
                w_emit = ~w_drain_done;
`ifdef FRAME_READER_ROW_MARKER_EN
                w_mark = (r_col == '0) && !r_mark_sent && (r_row < ROW_W'(IMAGE_HEIGHT));
`endif
                w_word = w_mark ? 17'h10001 : {1'b0, r_buf[r_didx[IDXA_W-1:0]]};
            end
            END_MARK: begin
                w_emit = 1'b1;
                w_word = 17'h1FFFF;
            end
            default: ;
        endcase
    end

    // A word is accepted on the edge where it is presented and the FIFO is not full.
    assign w_acc = w_emit & ~bus.out_full;

    // Capture read beats into the burst buffer.
    always_ff @(posedge clk) begin
        if (r_state == WAIT_DATA && bus.rd_data_valid) begin
            r_buf[w_lo] <= bus.rd_data[15:0];
            r_buf[w_hi] <= bus.rd_data[31:16];
        end
    end

    // Frame sequencing: start marker, issue/fill/drain per burst, end marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_cmd_en     <= 1'b0;
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;
            r_burst      <= '0;
            r_beat       <= '0;
            r_didx       <= '0;
            r_pix        <= '0;
`ifdef FRAME_READER_ROW_MARKER_EN
            r_col        <= '0;
            r_row        <= '0;
            r_mark_sent  <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            // Beats outside a burst window are dropped and flagged.
            if (bus.rd_data_valid && r_state != WAIT_DATA)
                r_error <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (bus.frame_req) begin
                        if (int'(bus.buf_sel) >= NUM_BUFFERS) begin
                            r_error <= 1'b1;
                        end else begin
                            r_addr      <= ADDR_WIDTH'(int'(bus.buf_sel) * FRAME_STRIDE);
                            r_burst     <= '0;
                            r_beat      <= '0;
                            r_didx      <= '0;
                            r_pix       <= '0;
`ifdef FRAME_READER_ROW_MARKER_EN
                            r_col       <= '0;
                            r_row       <= '0;
                            r_mark_sent <= 1'b0;
`endif
                            r_state     <= START_MARK;
                        end
                    end
                end
                START_MARK: begin
                    if (w_acc) begin
                        r_cmd_en <= 1'b1;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cmd_en <= 1'b0;
                    r_addr   <= r_addr + ADDR_WIDTH'(MEMORY_BURST);
                    r_burst  <= r_burst + 1'b1;
                    r_beat   <= '0;
                    r_state  <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (bus.rd_data_valid) begin
                        if (r_beat == BEAT_W'(BEATS - 1)) begin
                            r_beat  <= '0;
                            r_didx  <= '0;
                            r_state <= DRAIN;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_drain_done) begin
                        if (r_burst == BST_W'(NUM_BURSTS)) begin
                            r_state <= END_MARK;
                        end else begin
                            r_cmd_en <= 1'b1;
                            r_state  <= ISSUE;
                        end
                    end else if (w_acc) begin
                        if (w_mark) begin
`ifdef FRAME_READER_ROW_MARKER_EN
                            r_mark_sent <= 1'b1;
`endif
                        end else begin
                            r_didx <= r_didx + 1'b1;
                            r_pix  <= r_pix + 1'b1;
`ifdef FRAME_READER_ROW_MARKER_EN
                            r_mark_sent <= 1'b0;
                            if (r_col == COL_W'(IMAGE_WIDTH - 1)) begin
                                r_col <= '0;
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
`endif
                        end
                    end
                end
                END_MARK: begin
                    if (w_acc) begin
                        r_frame_done <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd        = 1'b0;
    assign bus.cmd_en     = r_cmd_en;
    assign bus.addr       = r_addr;
    assign bus.out_data   = w_word;
    assign bus.out_wr_en  = w_acc;
    assign bus.busy       = (r_state != IDLE);
    assign bus.frame_done = r_frame_done;
    assign bus.error      = r_error;
endmodule

// File: tb/tb_frame_stream_reader.sv
// tb_frame_stream_reader: directed bench for frame_stream_reader with a
// memory responder (random beat gaps), FIFO capture and optional random
// out_full stalls. Expected streams are rebuilt from the bench's memory image.
module tb_frame_stream_reader;
    localparam int W      = 23;
    localparam int H      = 17;
    localparam int NB     = 13;
`ifdef FRAME_READER_ROW_MARKER_EN
    localparam int NWORDS = 410;
`else
    localparam int NWORDS = 393;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_stream_reader_if bus ();

    frame_stream_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [0:1279];
    logic        resp_vld;
    logic [31:0] resp_data;
    logic        inj_vld;
    logic        stall_en;
    logic [16:0] got [$];
    int          cmds [$];
    int          done_cnt = 0;
    int          checks   = 0;
    int          failures = 0;
    int          base_tab [3] = '{0, 'h1A7, 'h34E};

    assign bus.rd_data_valid = resp_vld | inj_vld;
    assign bus.rd_data       = resp_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: answers each command with 16 beats after random gaps.
    initial begin : responder
        int a;
        resp_vld  = 1'b0;
        resp_data = '0;
        forever begin
            @(negedge clk);
            if (bus.cmd_en === 1'b1 && !rst) begin
                a = int'(bus.addr);
                @(negedge clk);
                for (int b = 0; b < 16; b++) begin
                    while ($urandom_range(0, 3) == 0) @(negedge clk);
                    resp_vld  = 1'b1;
                    resp_data = {mem[a + 2*b + 1], mem[a + 2*b]};
                    @(negedge clk);
                    resp_vld  = 1'b0;
                end
            end
        end
    end

    // FIFO back-pressure: random out_full while stalling is enabled.
    initial begin : stall_drv
        bus.out_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_full = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Capture written words, issued commands and done pulses.
    always @(negedge clk) begin
        if (bus.out_wr_en === 1'b1) got.push_back(bus.out_data);
        if (bus.cmd_en === 1'b1) cmds.push_back(int'(bus.addr));
        if (bus.frame_done === 1'b1) done_cnt++;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_frame(input int bsel, input bit stall, input bit timing, input string tag);
        int g0, c0, d0, n, base, bad, p;
        logic [16:0] exp [$];
        logic [16:0] lastw;
        base = base_tab[bsel];
        g0 = got.size();
        c0 = cmds.size();
        d0 = done_cnt;
        stall_en = stall;
        @(negedge clk);
        bus.frame_req = 1'b1;
        bus.buf_sel   = 2'(bsel);
        @(negedge clk);
        bus.frame_req = 1'b0;
        if (timing) begin
            chk({tag, "_busy_start"}, 32'(bus.busy), 1);
            chk({tag, "_start_wr"}, 32'(bus.out_wr_en), 1);
            chk({tag, "_start_word"}, 32'(bus.out_data), 32'h10000);
            @(negedge clk);
            chk({tag, "_cmd_en"}, 32'(bus.cmd_en), 1);
            chk({tag, "_first_addr"}, 32'(bus.addr), 32'(base));
        end
        n = 0;
        while (done_cnt == d0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        stall_en = 1'b0;
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
        chk({tag, "_busy_end"}, 32'(bus.busy), 0);
        exp.push_back(17'h10000);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
`ifdef FRAME_READER_ROW_MARKER_EN
                if (c == 0) exp.push_back(17'h10001);
`endif
                p = base + r*W + c;
                exp.push_back({1'b0, mem[p]});
            end
        exp.push_back(17'h1FFFF);
        chk({tag, "_words"}, 32'(got.size() - g0), 32'(NWORDS));
        bad = -1;
        for (int i = 0; i < exp.size() && g0 + i < got.size(); i++)
            if (got[g0 + i] !== exp[i]) begin
                bad = i;
                break;
            end
        chk({tag, "_first_bad_word"}, 32'(bad), 32'hFFFFFFFF);
        lastw = (got.size() > g0) ? got[got.size() - 1] : 17'h0;
        chk({tag, "_last_word"}, 32'(lastw), 32'h1FFFF);
        chk({tag, "_cmds"}, 32'(cmds.size() - c0), 32'(NB));
        bad = -1;
        for (int k = 0; k < NB && c0 + k < cmds.size(); k++)
            if (cmds[c0 + k] != base + k*32) begin
                bad = k;
                break;
            end
        chk({tag, "_first_bad_addr"}, 32'(bad), 32'hFFFFFFFF);
        if (cmds.size() >= c0 + NB)
            chk({tag, "_last_addr"}, 32'(cmds[c0 + NB - 1]), 32'(base + 'h180));
    endtask

    initial begin : main
        int g0, c0, n;
        bus.frame_req = 1'b0;
        bus.buf_sel   = '0;
        inj_vld       = 1'b0;
        stall_en      = 1'b0;
        for (int i = 0; i < 1280; i++) mem[i] = 16'($urandom);

        #1;
        chk("rst_cmd_en", 32'(bus.cmd_en), 0);
        chk("rst_addr", 32'(bus.addr), 0);
        chk("rst_out_wr_en", 32'(bus.out_wr_en), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_error", 32'(bus.error), 0);
        chk("rst_cmd", 32'(bus.cmd), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(0, 1'b0, 1'b1, "buf0");
        run_frame(1, 1'b0, 1'b1, "buf1");
        run_frame(2, 1'b0, 1'b0, "buf2");
        run_frame(0, 1'b1, 1'b0, "buf0_stall");
        chk("no_error_yet", 32'(bus.error), 0);

        // Out-of-range slot: flagged, frame not started.
        c0 = cmds.size();
        @(negedge clk);
        bus.frame_req = 1'b1;
        bus.buf_sel   = 2'd3;
        @(negedge clk);
        bus.frame_req = 1'b0;
        bus.buf_sel   = 2'd0;
        chk("badsel_error", 32'(bus.error), 1);
        chk("badsel_busy", 32'(bus.busy), 0);
        repeat (5) @(negedge clk);
        chk("badsel_no_cmd", 32'(cmds.size() - c0), 0);

        // Reset is the only way to clear the error flag.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("error_cleared", 32'(bus.error), 0);

        // Stray beat in IDLE: sticky error, next frame still correct.
        inj_vld = 1'b1;
        @(negedge clk);
        inj_vld = 1'b0;
        @(negedge clk);
        chk("stray_beat_error", 32'(bus.error), 1);
        run_frame(1, 1'b0, 1'b0, "after_err");
        chk("error_sticky", 32'(bus.error), 1);

        // Reset in the middle of draining the first burst.
        g0 = got.size();
        @(negedge clk);
        bus.frame_req = 1'b1;
        bus.buf_sel   = 2'd1;
        @(negedge clk);
        bus.frame_req = 1'b0;
        n = 0;
        while (got.size() - g0 < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_drain_reached", 32'(got.size() - g0 >= 10), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_out_wr_en", 32'(bus.out_wr_en), 0);
        chk("midrst_out_data", 32'(bus.out_data), 0);
        chk("midrst_cmd_en", 32'(bus.cmd_en), 0);
        chk("midrst_addr", 32'(bus.addr), 0);
        chk("midrst_error", 32'(bus.error), 0);
        @(negedge clk);
        rst = 1'b0;
        run_frame(2, 1'b0, 1'b1, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
